// File: rtl/data_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared definitions for the two-requester data memory arbiter: default
// widths, the lock watchdog limit, the arbiter state type and the requester
// identifier used by the round-robin pointer and the watchdog.
// -----------------------------------------------------------------------------
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LOCK_MAX = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/data_mem_arbiter_lock_watchdog.sv
// -----------------------------------------------------------------------------
// lock_watchdog
// Bounds how long one requester may keep the memory locked and blocks an
// immediate re-lock after a forced release.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   owning        arbiter is in OWN_A or OWN_B this cycle
//   owner         which requester holds the lock (valid while owning)
//   lock[1:0]     per-requester lock request, indexed by req_id_t
//   expire        combinational; this cycle is the last one the owner may hold
//   inhibit[1:0]  per-requester re-lock inhibit, cleared once lock is seen low
// -----------------------------------------------------------------------------
module lock_watchdog
  import data_mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       owning,
  input  req_id_t    owner,
  input  logic [1:0] lock,
  output logic       expire,
  output logic [1:0] inhibit
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] count;

  // The counter rests at zero outside ownership, so it already reads zero on
  // the cycle ownership begins. Expiry fires on the ownership cycle whose
  // increment would reach LOCK_MAX, giving exactly LOCK_MAX owned cycles.
  // A release requested in that same cycle is an ordinary release.
  assign expire = owning && lock[owner] && (count == CNT_W'(LOCK_MAX - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      inhibit <= '0;
    end else begin
      if (owning && !expire) count <= count + 1'b1;
      else                   count <= '0;

      if (expire && owner == REQ_A) inhibit[0] <= 1'b1;
      else if (!lock[0])            inhibit[0] <= 1'b0;

      if (expire && owner == REQ_B) inhibit[1] <= 1'b1;
      else if (!lock[1])            inhibit[1] <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Arbitrates two requesters (a, b) onto one single-port data memory with a
// combinational grant, round-robin tie breaking, optional bus locking and a
// lock watchdog.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   x_req/x_we/x_addr/x_wdata   per-requester access (x = a, b)
//   x_lock                      keep ownership after this access
//   x_gnt                       combinational; x's access happens this cycle
//   x_rvalid/x_rdata            registered read return, latency 1
//   mem_E/mem_WE/mem_Addr/
//   mem_Data_in                 memory command, zero when nothing is granted
//   mem_Data_out                combinational memory read data
//   lock_err                    sticky; a lock was forcibly released
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_E,
  output logic              mem_WE,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_Data_in,
  input  logic [DATA_W-1:0] mem_Data_out,

  output logic              lock_err
);

  arb_state_t state;
  req_id_t    ptr;      // most recently granted requester
  logic       owning;
  req_id_t    owner;
  logic       expire;
  logic [1:0] inhibit;

  assign owning = (state != IDLE);
  assign owner  = (state == OWN_B) ? REQ_B : REQ_A;

  lock_watchdog #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_watchdog (
    .clk     (clk),
    .rst     (rst),
    .owning  (owning),
    .owner   (owner),
    .lock    ({b_lock, a_lock}),
    .expire  (expire),
    .inhibit (inhibit)
  );

  // Grant selection. Reset masks grants combinationally so an access in
  // flight is dropped the moment rst rises, not at the next edge.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          // On a tie the requester not granted most recently wins.
          if (a_req && (!b_req || ptr == REQ_B)) a_gnt = 1'b1;
          else if (b_req)                        b_gnt = 1'b1;
        end
        OWN_A:   a_gnt = a_req;
        OWN_B:   b_gnt = b_req;
        default: ;
      endcase
    end
  end

  // Memory command mux; grants are one-hot so the priority order is moot.
  always_comb begin
    mem_E       = 1'b0;
    mem_WE      = 1'b0;
    mem_Addr    = '0;
    mem_Data_in = '0;
    if (a_gnt) begin
      mem_E       = 1'b1;
      mem_WE      = a_we;
      mem_Addr    = a_addr;
      mem_Data_in = a_wdata;
    end else if (b_gnt) begin
      mem_E       = 1'b1;
      mem_WE      = b_we;
      mem_Addr    = b_addr;
      mem_Data_in = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= REQ_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      lock_err <= 1'b0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= mem_Data_out;
      if (b_gnt && !b_we) b_rdata <= mem_Data_out;

      if (a_gnt)      ptr <= REQ_A;
      else if (b_gnt) ptr <= REQ_B;

      if (expire) lock_err <= 1'b1;

      case (state)
        IDLE: begin
          // A requester whose lock was forcibly broken cannot re-lock until
          // it has dropped x_lock once.
          if (a_gnt && a_lock && !inhibit[0])      state <= OWN_A;
          else if (b_gnt && b_lock && !inhibit[1]) state <= OWN_B;
        end
        OWN_A: begin
          if (expire) begin
            state <= IDLE;
            ptr   <= REQ_A;
          end else if (!a_lock) begin
            state <= IDLE;
          end
        end
        OWN_B: begin
          if (expire) begin
            state <= IDLE;
            ptr   <= REQ_B;
          end else if (!b_lock) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
